matrix_scroller: RTL and testbench
==================================

MATRIX_SCROLLER -- requirements
Module: matrix_scroller

Interface
REQ-001 Parameter COLS, default 5, column bits per display line.
REQ-002 Parameter ROWS, default 7, rows per displayed frame.
REQ-003 Parameter CHARS, default 3, glyphs held in the line buffer; DEPTH = ROWS*CHARS lines (default 21).
REQ-004 Parameter SCROLL_DIV, default 4, complete frames per one-line scroll step; SHALL be >= 1.
REQ-005 AW = ceil(log2(DEPTH)), minimum 1 (default 5).
REQ-006 clk  input  1  single clock, all logic on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  level, sampled each cycle; IDLE -> SCAN.
REQ-009 stop  input  1  level, sampled each cycle; SCAN -> IDLE at frame end.
REQ-010 dir  input  1  scroll direction: 0 = offset increments, 1 = offset decrements.
REQ-011 pause  input  1  freezes scroll offset; scanning continues.
REQ-012 wr_en  input  1  line-buffer write strobe.
REQ-013 wr_addr  input  AW  line index to write.
REQ-014 wr_data  input  COLS  line pattern to write.
REQ-015 row_sel  output  ROWS  registered one-hot active row.
REQ-016 col_data  output  COLS  registered column pattern for active row.
REQ-017 frame_start  output  1  registered, high with row 0 of each frame.
REQ-018 busy  output  1  registered, high while state is SCAN.

Function
REQ-019 FSM states: IDLE, SCAN; IDLE -> SCAN when start=1; SCAN -> IDLE on the cycle after row ROWS-1 is emitted if stop was sampled 1 at any cycle of that frame; start in SCAN is ignored; stop in IDLE is ignored.
REQ-020 In SCAN, each cycle: row_sel <= 1<<row, col_data <= buf[(offset+row) mod DEPTH], frame_start <= (row==0), then row <= (row+1) mod ROWS; output latency 1 cycle.
REQ-021 In IDLE, row_sel, col_data, frame_start, busy SHALL be 0; row, offset, frame counter hold (restart resumes at row 0 with retained offset).
REQ-022 On leaving SCAN, row resets to 0.
REQ-023 Frame counter increments when row ROWS-1 is emitted; on reaching SCROLL_DIV it clears to 0 and, if pause=0, offset steps by +1 (dir=0) or -1 (dir=1).
REQ-024 Offset wraps modulo DEPTH: DEPTH-1 +1 -> 0; 0 -1 -> DEPTH-1; never leaves range 0..DEPTH-1.
REQ-025 pause=1 at a step point: offset unchanged, frame counter still clears (step lost, not deferred).
REQ-026 dir changes take effect at the next step point only; offset update never occurs mid-frame.
REQ-027 Write: wr_en=1 with wr_addr < DEPTH stores wr_data at that line on the clock edge; wr_addr >= DEPTH ignored.
REQ-028 Write to the line being read in the same cycle: col_data gets old contents; new contents visible from next read.
REQ-029 Writes accepted in both IDLE and SCAN.

Reset
REQ-030 rst_n=0 asynchronously forces state IDLE, row=0, offset=0, frame counter=0, row_sel=0, col_data=0, frame_start=0, busy=0.
REQ-031 Line-buffer contents are not reset; reset mid-frame discards pending stop and partial frame count.
REQ-032 Reset release is synchronised to clk by the integrator; block needs no internal synchroniser.

Structure
REQ-033 Shared package holds state enum (IDLE, SCAN), default parameter constants and the AW function.
REQ-034 Line buffer is sub-module line_ram: DEPTH x COLS, one synchronous write port, one asynchronous read port, no reset.

Verification
REQ-035 Load glyph "A" (01110,01010,01110,01010,01010,00000,00000) at lines 0-6, start -> cycles 1-7 after start: row_sel 0000001..1000000, col_data as loaded, frame_start only on first.
REQ-036 SCROLL_DIV=4, dir=0: after 4 frames, frame 5 row 0 shows line 1; after 84 frames offset returns to 0.
REQ-037 dir=1 from offset 0: after 4 frames, row 0 shows line 20 (wrap).
REQ-038 pause=1 during frames 1-4: offset stays 0 in frame 5; release pause -> step after frame 8.
REQ-039 stop pulsed at row 3: remaining rows 4-6 emitted, next cycle busy=0, outputs 0; start again -> row 0 with retained offset.
REQ-040 rst_n low mid-frame -> all outputs 0 immediately without clk edge; buffer contents unchanged on restart.

Source files
------------

// File: rtl/matrix_scroller_pkg.sv
// Shared definitions for the matrix scroller: scan states, default geometry
// and the address-width helper used to size counters and buffer ports.
package matrix_scroller_pkg;

  localparam int DEF_COLS       = 5;
  localparam int DEF_ROWS       = 7;
  localparam int DEF_CHARS      = 3;
  localparam int DEF_SCROLL_DIV = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  // Bits needed to index n entries, never less than one.
  function automatic int calc_aw(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/matrix_scroller_line_ram.sv
// Line buffer for the scroller: one synchronous write port, one
// asynchronous read port, contents deliberately left unreset.
module line_ram
  import matrix_scroller_pkg::*;
#(
  parameter int COLS  = DEF_COLS,
  parameter int DEPTH = DEF_ROWS * DEF_CHARS,
  parameter int AW    = calc_aw(DEF_ROWS * DEF_CHARS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [COLS-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [COLS-1:0] rdata
);

  logic [COLS-1:0] mem [DEPTH];

  // Store a line; addresses past the last line are dropped.
  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < DEPTH)) mem[waddr] <= wdata;
  end

  // Combinational read, so a same-edge write is seen only on the next read.
  assign rdata = mem[raddr];

endmodule

// File: rtl/matrix_scroller.sv
// Row-multiplexed LED matrix driver that scans ROWS lines out of a circular
// line buffer and scrolls the visible window by one line every SCROLL_DIV
// frames.
module matrix_scroller
  import matrix_scroller_pkg::*;
#(
  parameter int  COLS       = DEF_COLS,
  parameter int  ROWS       = DEF_ROWS,
  parameter int  CHARS      = DEF_CHARS,
  parameter int  SCROLL_DIV = DEF_SCROLL_DIV,
  localparam int DEPTH      = ROWS * CHARS,
  localparam int AW         = calc_aw(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic            dir,
  input  logic            pause,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [COLS-1:0] wr_data,
  output logic [ROWS-1:0] row_sel,
  output logic [COLS-1:0] col_data,
  output logic            frame_start,
  output logic            busy
);

  localparam int RW = calc_aw(ROWS);
  localparam int FW = calc_aw(SCROLL_DIV);

  localparam logic [0:0] IDLE = ST_IDLE;
  localparam logic [0:0] SCAN = ST_SCAN;

  logic [0:0]      state;
  logic [RW-1:0]   row;
  logic [AW-1:0]   offset;
  logic [FW-1:0]   frame_cnt;
  logic            stop_seen;
  logic [AW-1:0]   rd_addr;
  logic [COLS-1:0] rd_data;
  logic            last_row;
  logic            step_due;

  // (base + r) mod DEPTH; both operands are below DEPTH so one fold suffices.
  function automatic logic [AW-1:0] wrap_index(input logic [AW-1:0] base,
                                               input logic [RW-1:0] r);
    logic [AW:0] sum;
    sum = {1'b0, base} + (AW+1)'(r);
    if (32'(sum) >= DEPTH) sum = sum - (AW+1)'(DEPTH);
    return sum[AW-1:0];
  endfunction

  // One scroll step with wrap at both ends of the buffer.
  function automatic logic [AW-1:0] step_offset(input logic [AW-1:0] cur,
                                                input logic down);
    if (down) return (cur == '0) ? AW'(DEPTH - 1) : cur - AW'(1);
    return (32'(cur) == DEPTH - 1) ? '0 : cur + AW'(1);
  endfunction

  assign last_row = (32'(row) == ROWS - 1);
  assign step_due = (32'(frame_cnt) == SCROLL_DIV - 1);
  assign rd_addr  = wrap_index(offset, row);

  line_ram #(
    .COLS  (COLS),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_line_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Scan control: row sequencing, stop latching at frame end, frame counting
  // and scroll stepping, all confined to the edge that emits the last row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row       <= '0;
      offset    <= '0;
      frame_cnt <= '0;
      stop_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          stop_seen <= 1'b0;
          if (start) state <= SCAN;
        end
        SCAN: begin
          if (last_row) begin
            row       <= '0;
            stop_seen <= 1'b0;
            if (stop || stop_seen) state <= IDLE;
            if (step_due) begin
              frame_cnt <= '0;
              if (!pause) offset <= step_offset(offset, dir);
            end else begin
              frame_cnt <= frame_cnt + FW'(1);
            end
          end else begin
            row <= row + RW'(1);
            if (stop) stop_seen <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered display outputs, forced to zero whenever not scanning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_sel     <= '0;
      col_data    <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else if (state == SCAN) begin
      row_sel     <= ROWS'(1) << row;
      col_data    <= rd_data;
      frame_start <= (row == '0);
      busy        <= 1'b1;
    end else begin
      row_sel     <= '0;
      col_data    <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matrix_scroller.sv
// Self-checking bench for matrix_scroller: a frame-level reference model
// (line array, visible offset, frames since last step) predicts every row.
module tb_matrix_scroller;

  localparam int COLS  = 5;
  localparam int ROWS  = 7;
  localparam int CHARS = 3;
  localparam int SD    = 4;
  localparam int DEPTH = ROWS * CHARS;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic            dir = 1'b0;
  logic            pause = 1'b0;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [COLS-1:0] wr_data = '0;
  logic [ROWS-1:0] row_sel;
  logic [COLS-1:0] col_data;
  logic            frame_start;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int mem_m [DEPTH];
  int off_m = 0;
  int frames_m = 0;
  int glyph [7] = '{14, 10, 14, 10, 10, 0, 0};

  always #5 clk = ~clk;

  matrix_scroller #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .CHARS      (CHARS),
    .SCROLL_DIV (SD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .dir         (dir),
    .pause       (pause),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .row_sel     (row_sel),
    .col_data    (col_data),
    .frame_start (frame_start),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_row_sel"}, 32'(row_sel), 32'(0));
    chk({tag, "_col_data"}, 32'(col_data), 32'(0));
    chk({tag, "_frame_start"}, 32'(frame_start), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  task automatic do_write(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = COLS'(d);
    tick();
    wr_en = 1'b0;
    if (a < DEPTH) mem_m[a] = d;
  endtask

  task automatic start_scan();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'(0));
    chk("start_row_sel", 32'(row_sel), 32'(0));
  endtask

  // Emit nrows rows of one frame; a full frame advances the model's scroll.
  task automatic run_frame(input int stop_row, input bit rnd_wr,
                           input int same_row, input int nrows);
    int a, d, idx;
    bit we, stopped;
    stopped = 1'b0;
    for (int r = 0; r < nrows; r++) begin
      stop = (r == stop_row);
      we = 1'b0; a = 0; d = 0;
      if (r == same_row) begin
        we = 1'b1; a = (off_m + r) % DEPTH; d = $urandom_range(0, 31);
      end else if (rnd_wr && ($urandom_range(0, 3) == 0)) begin
        we = 1'b1; a = $urandom_range(0, 31); d = $urandom_range(0, 31);
      end
      wr_en = we; wr_addr = AW'(a); wr_data = COLS'(d);
      idx = (off_m + r) % DEPTH;
      tick();
      chk("row_sel", 32'(row_sel), 32'(1 << r));
      chk("col_data", 32'(col_data), 32'(mem_m[idx]));
      chk("frame_start", 32'(frame_start), 32'(r == 0));
      chk("busy", 32'(busy), 32'(1));
      if (we && a < DEPTH) mem_m[a] = d;
      if (r == stop_row) stopped = 1'b1;
    end
    stop = 1'b0;
    wr_en = 1'b0;
    if (nrows == ROWS) begin
      frames_m++;
      if (frames_m == SD) begin
        frames_m = 0;
        if (!pause) off_m = dir ? (off_m + DEPTH - 1) % DEPTH : (off_m + 1) % DEPTH;
      end
      if (stopped) begin
        tick();
        check_idle("after_stop");
      end
    end
  endtask

  initial begin
    // Reset state.
    #12;
    check_idle("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Glyph "A" in lines 0-6, random content elsewhere, out-of-range writes.
    for (int i = 0; i < 7; i++) do_write(i, glyph[i]);
    for (int i = 7; i < DEPTH; i++) do_write(i, $urandom_range(0, 31));
    do_write(21, 31);
    do_write(31, 21);
    check_idle("idle_after_load");

    // First frame shows the glyph; 84 frames bring the offset back to 0.
    start_scan();
    for (int f = 0; f < 84; f++) run_frame(-1, f >= 5, -1, ROWS);

    // Scroll downwards from offset 0: wraps to line 20.
    dir = 1'b1;
    for (int f = 0; f < 8; f++) run_frame(-1, 1'b0, -1, ROWS);

    // Pause across one step point, then release.
    dir = 1'b0;
    pause = 1'b1;
    for (int f = 0; f < 4; f++) run_frame(-1, 1'b0, -1, ROWS);
    pause = 1'b0;
    for (int f = 0; f < 5; f++) run_frame(-1, 1'b0, -1, ROWS);

    // Randomised direction/pause, writes, and same-line write/read hits.
    for (int f = 0; f < 24; f++) begin
      dir   = 1'($urandom_range(0, 1));
      pause = ($urandom_range(0, 3) == 0);
      start = 1'($urandom_range(0, 1));
      run_frame(-1, 1'b1, $urandom_range(0, ROWS - 1), ROWS);
    end
    start = 1'b0;
    pause = 1'b0;

    // Stop at row 3: frame finishes, then outputs drop; stop in idle ignored.
    run_frame(3, 1'b1, -1, ROWS);
    stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("idle_stop_held");
    end
    stop = 1'b0;
    start_scan();
    run_frame(-1, 1'b1, -1, ROWS);
    run_frame(-1, 1'b1, -1, ROWS);

    // Asynchronous reset mid-frame with a pending stop that must be discarded.
    run_frame(1, 1'b0, -1, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    tick();
    rst_n = 1'b1;
    off_m = 0;
    frames_m = 0;
    tick();
    check_idle("post_reset");
    start_scan();
    for (int f = 0; f < 6; f++) run_frame(-1, 1'b0, -1, ROWS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
